// File: rtl/int_vector_responder.sv
// rtl/int_vector_responder.sv - IM2 interrupt request/acknowledge/RETI responder
//
// Latches one-cycle interrupt strobes, pulls the CPU INT line for a bounded
// number of CPU clock ticks, answers the IM2 acknowledge with a per-source
// vector and holds that source in service until a RETI opcode fetch.
//
// Ports:
//   clk28                 system clock, all logic on its rising edge
//   rst                   synchronous active-high reset
//   clkcpu_ck             one-clk28 pulse per CPU clock rising edge
//   bus_m1/iorq/mreq/rd   CPU cycle qualifiers (active-high)
//   bus_d                 CPU data bus, snooped for ED 4D
//   irq_strobe            per-source request pulses
//   irq_mask              per-source enable
//   n_int                 CPU interrupt request, active-low
//   vector, vector_oe     vector byte and its bus drive enable
//   in_service            one-hot source currently being serviced
module int_vector_responder #(
  parameter int          NSRC        = 4,
  parameter logic [7:0]  VECTOR_BASE = 8'hF0,
  parameter int          INT_LEN     = 32
) (
  input  logic            clk28,
  input  logic            rst,
  input  logic            clkcpu_ck,
  input  logic            bus_m1,
  input  logic            bus_iorq,
  input  logic            bus_mreq,
  input  logic            bus_rd,
  input  logic [7:0]      bus_d,
  input  logic [NSRC-1:0] irq_strobe,
  input  logic [NSRC-1:0] irq_mask,
  output logic            n_int,
  output logic [7:0]      vector,
  output logic            vector_oe,
  output logic [NSRC-1:0] in_service
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_ACK,
    S_SERVICE,
    S_GAP
  } state_t;

  localparam logic [5:0] CNT_LAST = 6'(INT_LEN - 1);

  state_t          state, state_nx;
  logic [NSRC-1:0] pending, pending_nx, pending_clr;
  logic [NSRC-1:0] req, win_oh;
  logic [1:0]      win_idx;
  logic [5:0]      cnt, cnt_nx;
  logic            n_int_nx, vector_oe_nx;
  logic [7:0]      vector_nx;
  logic [NSRC-1:0] in_service_nx;

  logic            ack_cyc, ack_d, ack_rise;
  logic            fetch, fetch_d, fetch_done;
  logic [7:0]      d_reg;
  logic            ed_seen;
  logic            reti;
  logic            tick_last;

  assign req      = pending & irq_mask;
  // Isolate the lowest set bit: lowest index has priority.
  assign win_oh   = req & (~req + NSRC'(1));

  always_comb begin
    win_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) win_idx = 2'(i);
    end
  end

  assign ack_cyc    = bus_m1 & bus_iorq;
  assign ack_rise   = ack_cyc & ~ack_d;
  assign fetch      = bus_m1 & bus_mreq & bus_rd;
  assign fetch_done = fetch_d & ~fetch;
  // The byte captured during the fetch is judged on the cycle the fetch ends.
  assign reti       = fetch_done & ed_seen & (d_reg == 8'h4D);
  // Transition on the final tick itself so the line changes the next cycle.
  assign tick_last  = clkcpu_ck & (cnt == CNT_LAST);

  always_ff @(posedge clk28) begin
    if (rst) begin
      state      <= S_IDLE;
      pending    <= '0;
      cnt        <= '0;
      n_int      <= 1'b1;
      vector     <= 8'hFF;
      vector_oe  <= 1'b0;
      in_service <= '0;
      ack_d      <= 1'b0;
      fetch_d    <= 1'b0;
      d_reg      <= '0;
      ed_seen    <= 1'b0;
    end else begin
      state      <= state_nx;
      pending    <= pending_nx;
      cnt        <= cnt_nx;
      n_int      <= n_int_nx;
      vector     <= vector_nx;
      vector_oe  <= vector_oe_nx;
      in_service <= in_service_nx;
      ack_d      <= ack_cyc;
      fetch_d    <= fetch;
      if (fetch) d_reg <= bus_d;
      // ED arms, everything else (including the 4D that completes RETI) disarms.
      if (fetch_done) ed_seen <= (d_reg == 8'hED);
    end
  end

  always_comb begin
    state_nx      = state;
    pending_clr   = '0;
    n_int_nx      = n_int;
    vector_nx     = vector;
    vector_oe_nx  = 1'b0;
    in_service_nx = in_service;
    cnt_nx        = (clkcpu_ck && cnt != 6'h3F) ? cnt + 6'd1 : cnt;

    case (state)
      S_IDLE: begin
        n_int_nx = 1'b1;
        if (ack_cyc) begin
          vector_nx    = 8'hFF;
          vector_oe_nx = 1'b1;
        end
        if (|req) begin
          state_nx = S_ASSERT;
          n_int_nx = 1'b0;
          cnt_nx   = '0;
        end
      end
      S_ASSERT: begin
        n_int_nx = 1'b0;
        if (ack_rise && |req) begin
          // Acknowledge beats a coincident final tick.
          state_nx      = S_ACK;
          n_int_nx      = 1'b1;
          pending_clr   = win_oh;
          in_service_nx = win_oh;
          vector_nx     = {VECTOR_BASE[7:3], win_idx, 1'b0};
          vector_oe_nx  = 1'b1;
        end else begin
          // Acknowledge with nothing enabled left to serve answers FF.
          if (ack_cyc) begin
            vector_nx    = 8'hFF;
            vector_oe_nx = 1'b1;
          end
          if (tick_last) begin
            state_nx = S_GAP;
            n_int_nx = 1'b1;
            cnt_nx   = '0;
          end
        end
      end
      S_ACK: begin
        n_int_nx = 1'b1;
        if (ack_cyc) begin
          vector_oe_nx = 1'b1;
        end else begin
          state_nx  = S_SERVICE;
          vector_nx = 8'hFF;
        end
      end
      S_SERVICE: begin
        n_int_nx = 1'b1;
        if (ack_cyc) begin
          vector_nx    = 8'hFF;
          vector_oe_nx = 1'b1;
        end
        if (reti) begin
          state_nx      = S_IDLE;
          in_service_nx = '0;
        end
      end
      S_GAP: begin
        n_int_nx = 1'b1;
        if (ack_cyc) begin
          vector_nx    = 8'hFF;
          vector_oe_nx = 1'b1;
        end
        if (tick_last) state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
        n_int_nx = 1'b1;
      end
    endcase

    // A strobe landing on the same bit as an acknowledge clear keeps it set.
    pending_nx = (pending & ~pending_clr) | irq_strobe;
  end

endmodule

// File: tb/tb_int_vector_responder.sv
// tb/tb_int_vector_responder.sv - self-checking bench for int_vector_responder
module tb_int_vector_responder;

  logic       clk28 = 1'b0;
  logic       rst;
  logic       clkcpu_ck = 1'b0;
  logic       bus_m1, bus_iorq, bus_mreq, bus_rd;
  logic [7:0] bus_d;
  logic [3:0] irq_strobe, irq_mask;
  logic       n_int;
  logic [7:0] vector;
  logic       vector_oe;
  logic [3:0] in_service;

  int passed = 0;
  int total  = 0;
  int div    = 0;

  int_vector_responder #(.NSRC(4), .VECTOR_BASE(8'hF0), .INT_LEN(32)) dut (
    .clk28(clk28), .rst(rst), .clkcpu_ck(clkcpu_ck),
    .bus_m1(bus_m1), .bus_iorq(bus_iorq), .bus_mreq(bus_mreq), .bus_rd(bus_rd),
    .bus_d(bus_d), .irq_strobe(irq_strobe), .irq_mask(irq_mask),
    .n_int(n_int), .vector(vector), .vector_oe(vector_oe), .in_service(in_service)
  );

  always #5 clk28 = ~clk28;

  // CPU clock tick every 4th clk28 cycle.
  always @(posedge clk28) begin
    #1;
    div = (div + 1) % 4;
    clkcpu_ck = (div == 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] strb;
    logic [3:0] mask;
    bit         exp_int;
    logic [7:0] exp_vec;
    logic [3:0] exp_isv;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc;
    @(posedge clk28);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    irq_strobe = '0;
    cyc;
    rst = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] s);
    irq_strobe = s;
    cyc;
    irq_strobe = '0;
  endtask

  task automatic wait_int(input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (n_int === 1'b0) begin
        found = 1'b1;
        break;
      end
      cyc;
    end
    if (n_int === 1'b0) found = 1'b1;
  endtask

  task automatic do_ack(input string nm, input logic [3:0] s_during,
                        input logic [7:0] ev, input logic [3:0] eisv);
    bus_m1 = 1'b1;
    bus_iorq = 1'b1;
    irq_strobe = s_during;
    cyc;
    irq_strobe = '0;
    chk({nm, " oe"}, vector_oe, 1);
    chk({nm, " vec"}, vector, ev);
    chk({nm, " isv"}, in_service, eisv);
    chk({nm, " nint"}, n_int, 1);
    cyc;
    chk({nm, " vec hold"}, vector, ev);
    bus_m1 = 1'b0;
    bus_iorq = 1'b0;
    cyc;
    chk({nm, " oe off"}, vector_oe, 0);
  endtask

  task automatic fetch(input logic [7:0] b, input logic m1v);
    bus_m1 = m1v;
    bus_mreq = 1'b1;
    bus_rd = 1'b1;
    bus_d = b;
    cyc;
    cyc;
    bus_m1 = 1'b0;
    bus_mreq = 1'b0;
    bus_rd = 1'b0;
    cyc;
  endtask

  task automatic reti;
    fetch(8'hED, 1'b1);
    fetch(8'h4D, 1'b1);
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    bit         found;
    int         ticks, n;
    bit         lasttick;
    logic [3:0] pend, msk, s;
    int         e;

    tbl[0] = '{4'b0001, 4'hF,    1'b1, 8'hF0, 4'b0001};
    tbl[1] = '{4'b0010, 4'hF,    1'b1, 8'hF2, 4'b0010};
    tbl[2] = '{4'b0100, 4'hF,    1'b1, 8'hF4, 4'b0100};
    tbl[3] = '{4'b1000, 4'hF,    1'b1, 8'hF6, 4'b1000};
    tbl[4] = '{4'b1010, 4'hF,    1'b1, 8'hF2, 4'b0010};
    tbl[5] = '{4'b1100, 4'hF,    1'b1, 8'hF4, 4'b0100};
    tbl[6] = '{4'b1111, 4'b1110, 1'b1, 8'hF2, 4'b0010};
    tbl[7] = '{4'b1000, 4'b0111, 1'b0, 8'hFF, 4'b0000};
    tbl[8] = '{4'b0110, 4'b1001, 1'b0, 8'hFF, 4'b0000};

    rst = 1'b1; bus_m1 = 0; bus_iorq = 0; bus_mreq = 0; bus_rd = 0;
    bus_d = '0; irq_strobe = '0; irq_mask = 4'hF;
    cyc; cyc;
    rst = 1'b0;
    chk("reset nint", n_int, 1);
    chk("reset vec", vector, 8'hFF);
    chk("reset oe", vector_oe, 0);
    chk("reset isv", in_service, 0);

    // Single request: strobe-to-INT latency, acknowledge, RETI variants.
    irq_strobe = 4'b0100;
    cyc;
    irq_strobe = '0;
    chk("latency N+1", n_int, 1);
    cyc;
    chk("latency N+2", n_int, 0);
    do_ack("single", 4'b0000, 8'hF4, 4'b0100);
    fetch(8'hED, 1'b1); fetch(8'h00, 1'b1); fetch(8'h4D, 1'b1);
    chk("reti ED 00 4D", in_service, 4'b0100);
    fetch(8'hED, 1'b0); fetch(8'h4D, 1'b0);
    chk("reti non-m1", in_service, 4'b0100);
    fetch(8'hED, 1'b1); fetch(8'h4D, 1'b0);
    chk("reti 4D non-m1", in_service, 4'b0100);
    fetch(8'hED, 1'b1); fetch(8'h4D, 1'b1);
    chk("reti release", in_service, 4'b0000);
    cyc; cyc; cyc;
    chk("single no reint", n_int, 1);

    // Timeout and retry gap.
    do_reset;
    strobe(4'b0001);
    wait_int(10, found);
    chk("timeout int", found, 1);
    ticks = 0; n = 0; lasttick = 0;
    while (n_int === 1'b0 && n < 400) begin
      lasttick = clkcpu_ck;
      if (clkcpu_ck) ticks++;
      cyc; n++;
    end
    chk("int len ticks", ticks, 32);
    chk("int ends after tick", lasttick, 1);
    ticks = 0; n = 0;
    while (n_int === 1'b1 && n < 400) begin
      if (clkcpu_ck) ticks++;
      cyc; n++;
    end
    chk("gap ticks", ticks, 32);
    chk("reassert", n_int, 0);
    do_ack("timeout", 4'b0000, 8'hF0, 4'b0001);
    reti;
    chk("timeout release", in_service, 0);

    // Priority and RETI-to-request latency.
    do_reset;
    strobe(4'b1010);
    wait_int(10, found);
    chk("prio int", found, 1);
    do_ack("prio1", 4'b0000, 8'hF2, 4'b0010);
    reti;
    chk("prio release", in_service, 0);
    chk("prio idle", n_int, 1);
    cyc;
    chk("prio reassert", n_int, 0);
    do_ack("prio2", 4'b0000, 8'hF6, 4'b1000);
    reti;

    // Masking and set-wins.
    do_reset;
    irq_mask = 4'b1101;
    strobe(4'b0010);
    wait_int(20, found);
    chk("masked no int", found, 0);
    irq_mask = 4'hF;
    wait_int(5, found);
    chk("unmask int", found, 1);
    do_ack("setwins", 4'b0010, 8'hF2, 4'b0010);
    reti;
    wait_int(5, found);
    chk("setwins reint", found, 1);
    do_ack("setwins2", 4'b0000, 8'hF2, 4'b0010);
    reti;

    // Reset during acknowledge.
    do_reset;
    strobe(4'b1000);
    wait_int(10, found);
    bus_m1 = 1'b1; bus_iorq = 1'b1;
    cyc;
    chk("pre-reset oe", vector_oe, 1);
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    chk("midrst nint", n_int, 1);
    chk("midrst vec", vector, 8'hFF);
    chk("midrst oe", vector_oe, 0);
    chk("midrst isv", in_service, 0);
    bus_m1 = 1'b0; bus_iorq = 1'b0;
    wait_int(10, found);
    chk("midrst no pending", found, 0);

    // Spurious acknowledge in IDLE.
    bus_m1 = 1'b1; bus_iorq = 1'b1;
    cyc;
    chk("spur oe", vector_oe, 1);
    chk("spur vec", vector, 8'hFF);
    chk("spur nint", n_int, 1);
    bus_m1 = 1'b0; bus_iorq = 1'b0;
    cyc;
    chk("spur oe off", vector_oe, 0);
    chk("spur isv", in_service, 0);
    strobe(4'b0001);
    wait_int(5, found);
    chk("post-spur int", found, 1);
    do_ack("post-spur", 4'b0000, 8'hF0, 4'b0001);
    reti;

    // Table-driven vectors.
    for (int k = 0; k < 9; k++) begin
      do_reset;
      irq_mask = tbl[k].mask;
      strobe(tbl[k].strb);
      wait_int(10, found);
      chk($sformatf("tbl%0d int", k), found, tbl[k].exp_int);
      if (found && tbl[k].exp_int) begin
        do_ack($sformatf("tbl%0d", k), 4'b0000, tbl[k].exp_vec, tbl[k].exp_isv);
        reti;
        chk($sformatf("tbl%0d release", k), in_service, 0);
      end
    end

    // Randomized requests against a set-of-pending reference model.
    for (int it = 0; it < 12; it++) begin
      do_reset;
      msk = 4'($urandom_range(0, 15));
      s   = 4'($urandom_range(1, 15));
      irq_mask = msk;
      strobe(s);
      pend = s;
      for (int r = 0; r < 5; r++) begin
        if ((pend & msk) == 4'b0) begin
          wait_int(20, found);
          chk($sformatf("rand%0d idle", it), found, 0);
          break;
        end
        wait_int(10, found);
        chk($sformatf("rand%0d int", it), found, 1);
        if (!found) break;
        e = lowest(pend & msk);
        do_ack($sformatf("rand%0d", it), 4'b0000, {5'b11110, 2'(e), 1'b0}, 4'(1 << e));
        pend[e] = 1'b0;
        reti;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
